sram_arbiter: RTL

Shares the single external SRAM between the two audio-rate SRAM users in the pedal: the delay line (requester 0) and the looper record/playback engine (requester 1). Each requester issues single-word read or write requests with a req/gnt handshake. The arbiter serializes them with round-robin priority and drives the SRAM pins with fixed-length access cycles. It returns read data and a done pulse to the requester that issued the access. It sits between the effect/looper datapaths and the `o_SRAM_*` / `io_SRAM_DQ` top-level pins.

---
 rtl/sram_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one async SRAM between the delay line (r0)
// and the looper (r1); fixed-length access cycles, per-requester rdata/done.
module sram_arbiter #(
   parameter int ACC_CYC = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_r0_req,
   input  logic        i_r0_we,
   input  logic [19:0] i_r0_addr,
   input  logic [15:0] i_r0_wdata,
   input  logic        i_r1_req,
   input  logic        i_r1_we,
   input  logic [19:0] i_r1_addr,
   input  logic [15:0] i_r1_wdata,
   output logic        o_r0_gnt,
   output logic        o_r1_gnt,
   output logic        o_r0_done,
   output logic        o_r1_done,
   output logic [15:0] o_r0_rdata,
   output logic [15:0] o_r1_rdata,
   output logic        o_busy,
   output logic [19:0] o_SRAM_ADDR,
   inout  wire  [15:0] io_SRAM_DQ,
   output logic        o_SRAM_WE_N,
   output logic        o_SRAM_CE_N,
   output logic        o_SRAM_OE_N,
   output logic        o_SRAM_LB_N,
   output logic        o_SRAM_UB_N
);

   localparam logic [3:0] LAST = 4'(ACC_CYC - 1);

   typedef enum logic {IDLE, ACC} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic        last;
   logic        own;
   logic        we_q;
   logic [19:0] addr_q;
   logic [15:0] wdata_q;
   logic        dq_oe;
   logic        xfer;
   logic        acc_end;

   // Grants are suppressed during reset so no transfer is signalled then.
   always_comb begin
      o_r0_gnt = 1'b0;
      o_r1_gnt = 1'b0;
      if (state == IDLE && !i_rst) begin
         if (i_r0_req && i_r1_req) begin
            o_r0_gnt = last;
            o_r1_gnt = !last;
         end else begin
            o_r0_gnt = i_r0_req;
            o_r1_gnt = i_r1_req;
         end
      end
   end

   assign xfer    = o_r0_gnt | o_r1_gnt;
   assign acc_end = (state == ACC) && (cnt == LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (xfer)    state_nxt = ACC;
         ACC:  if (acc_end) state_nxt = IDLE;
         default:           state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy      = (state == ACC);
      o_SRAM_ADDR = '0;
      o_SRAM_CE_N = 1'b1;
      o_SRAM_OE_N = 1'b1;
      o_SRAM_WE_N = 1'b1;
      o_SRAM_LB_N = 1'b1;
      o_SRAM_UB_N = 1'b1;
      dq_oe       = 1'b0;
      if (state == ACC) begin
         o_SRAM_ADDR = addr_q;
         o_SRAM_CE_N = 1'b0;
         o_SRAM_LB_N = 1'b0;
         o_SRAM_UB_N = 1'b0;
         if (we_q) begin
            o_SRAM_WE_N = 1'b0;
            dq_oe       = 1'b1;
         end else begin
            o_SRAM_OE_N = 1'b0;
         end
      end
   end

   assign io_SRAM_DQ = dq_oe ? wdata_q : 16'hzzzz;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt       <= '0;
         last      <= 1'b1;
         own       <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         o_r0_done <= 1'b0;
         o_r1_done <= 1'b0;
      end else begin
         o_r0_done <= acc_end && !own;
         o_r1_done <= acc_end && own;
         if (xfer) begin
            cnt     <= '0;
            last    <= o_r1_gnt;
            own     <= o_r1_gnt;
            we_q    <= o_r1_gnt ? i_r1_we    : i_r0_we;
            addr_q  <= o_r1_gnt ? i_r1_addr  : i_r0_addr;
            wdata_q <= o_r1_gnt ? i_r1_wdata : i_r0_wdata;
         end else if (state == ACC) begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   // A reset that cuts an access short keeps earlier read results.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         if (state == IDLE) begin
            o_r0_rdata <= '0;
            o_r1_rdata <= '0;
         end
      end else if (acc_end && !we_q) begin
         if (own) o_r1_rdata <= io_SRAM_DQ;
         else     o_r0_rdata <= io_SRAM_DQ;
      end
   end

endmodule
